// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: input side (imm/op) and output side (operand/err).
// Master drives requests and out_ready; slave (the extender) drives the responses.
interface ext_pipe_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned IW  = 26,
  parameter int unsigned OPW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_imm;
  logic [OPW-1:0] in_op;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_err;

  modport master (
    output in_valid, in_imm, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_op, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// Registered immediate extender with valid/ready handshake.
// Turns a raw instruction immediate plus an extension opcode into a DW-bit operand one cycle later,
// holds it under back-pressure and drops it on flush. Undefined opcodes give zero data with out_err.
// Optional feature macro EXT_PIPE_SKID_EN: adds a one-entry skid buffer behind the output register
// so in_ready becomes a registered signal with no combinational path from out_ready.
// Interface parameters must match the module parameters.
module ext_pipe #(
  parameter int unsigned DW  = 32,
  parameter int unsigned IW  = 26,
  parameter int unsigned OPW = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  ext_pipe_if.slave bus
);

  if (DW < 32) begin : g_dw_chk
    $error("ext_pipe: DW must be >= 32");
  end
  if (IW < 26) begin : g_iw_chk
    $error("ext_pipe: IW must be >= 26");
  end
  if (OPW < 3) begin : g_opw_chk
    $error("ext_pipe: OPW must be >= 3");
  end

  localparam logic [OPW-1:0] OpZe16 = OPW'(0);
  localparam logic [OPW-1:0] OpSe16 = OPW'(1);
  localparam logic [OPW-1:0] OpZe26 = OPW'(2);
  localparam logic [OPW-1:0] OpLui  = OPW'(3);
  localparam logic [OPW-1:0] OpBr   = OPW'(4);
  localparam logic [OPW-1:0] OpJmp  = OPW'(5);
  localparam logic [OPW-1:0] OpSe8  = OPW'(6);
  localparam logic [OPW-1:0] OpZe8  = OPW'(7);

  logic [DW-1:0] se16;
  logic [DW-1:0] ext_data;
  logic          ext_err;
  logic          accept;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic          out_err_q,   out_err_d;

  // Combinational extension of the incoming immediate according to in_op.
  always_comb begin
    se16     = {{(DW-16){bus.in_imm[15]}}, bus.in_imm[15:0]};
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus.in_op)
      OpZe16:  ext_data = {{(DW-16){1'b0}}, bus.in_imm[15:0]};
      OpSe16:  ext_data = se16;
      OpZe26:  ext_data = {{(DW-26){1'b0}}, bus.in_imm[25:0]};
      // Sign-extending imm16 then shifting by 16 equals sign extension from bit 31.
      OpLui:   ext_data = se16 << 16;
      OpBr:    ext_data = se16 << 2;
      OpJmp:   ext_data = {{(DW-28){1'b0}}, bus.in_imm[25:0], 2'b00};
      OpSe8:   ext_data = {{(DW-8){bus.in_imm[7]}}, bus.in_imm[7:0]};
      OpZe8:   ext_data = {{(DW-8){1'b0}}, bus.in_imm[7:0]};
      default: ext_err  = 1'b1;
    endcase
  end

`ifdef EXT_PIPE_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;
  logic          skid_err_q,   skid_err_d;
  logic          drain;

  assign bus.in_ready = !skid_valid_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = !out_valid_q || bus.out_ready;

  // Next state: output register refills from skid first so ordering is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_err_d    = 1'b0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_err_d   = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no input transfer can coincide.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
        skid_err_d   = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_data;
        out_err_d   = ext_err;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_err_d   = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_err_d   = ext_err;
    end
  end

  // Skid entry register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
    end
  end
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Next state: load on input transfer, clear on drain or flush, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_err_d   = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_data;
      out_err_d   = ext_err;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_err_d   = 1'b0;
    end
  end
`endif

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: stimulus pushes expected results, a negedge monitor pops/compares.
module tb_ext_pipe;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ext_pipe_if #(.DW(32), .IW(26), .OPW(4)) bus ();
  ext_pipe_if #(.DW(64), .IW(26), .OPW(4)) b64 ();

  ext_pipe #(.DW(32), .IW(26), .OPW(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  ext_pipe #(.DW(64), .IW(26), .OPW(4)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b64)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  bit lat_chk = 1'b0;

  logic [31:0] cur_exp_data;
  logic        cur_exp_err;
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference extension for DW=32.
  function automatic void model(input logic [25:0] imm, input logic [3:0] op,
                                output logic [31:0] d, output logic e);
    logic [31:0] s16;
    s16 = imm[15] ? {16'hFFFF, imm[15:0]} : {16'h0000, imm[15:0]};
    e = 1'b0;
    case (op)
      4'd0:    d = {16'h0000, imm[15:0]};
      4'd1:    d = s16;
      4'd2:    d = {6'h00, imm};
      4'd3:    d = {imm[15:0], 16'h0000};
      4'd4:    d = {s16[29:0], 2'b00};
      4'd5:    d = {4'h0, imm, 2'b00};
      4'd6:    d = imm[7] ? {24'hFFFFFF, imm[7:0]} : {24'h000000, imm[7:0]};
      4'd7:    d = {24'h000000, imm[7:0]};
      default: begin d = 32'h0; e = 1'b1; end
    endcase
  endfunction

  // Monitor: pop/compare on output transfer, check hold-stability while stalled, push on accept.
  always @(negedge clk) begin
    if (reset) begin
      if (flush) begin
        exp_data_q.delete();
        exp_err_q.delete();
        exp_cyc_q.delete();
      end else begin
        if (bus.out_valid) begin
          if (exp_data_q.size() == 0) begin
            fail_now("unexpected_out_valid");
          end else if (bus.out_ready) begin
            check("out_data", 64'(bus.out_data), 64'(exp_data_q.pop_front()));
            check("out_err", 64'(bus.out_err), 64'(exp_err_q.pop_front()));
            if (lat_chk) check("latency", 64'(cyc - exp_cyc_q[0]), 64'd1);
            void'(exp_cyc_q.pop_front());
            n_out++;
          end else begin
            check("hold_stable", 64'(bus.out_data), 64'(exp_data_q[0]));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_data_q.push_back(cur_exp_data);
          exp_err_q.push_back(cur_exp_err);
          exp_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [25:0] imm, input logic [3:0] op,
                       input logic [31:0] exp, input logic err);
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_op    = op;
    cur_exp_data = exp;
    cur_exp_err  = err;
  endtask

  // Keep in_valid up until accepted (bounded), then drop it.
  task automatic wait_accept(input string name);
    int w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 20) begin
        fail_now(name);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [25:0] imm, input logic [3:0] op,
                      input logic [31:0] exp, input logic err);
    drive(imm, op, exp, err);
    wait_accept("send_timeout");
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_data_q.size() != 0 && w < 20) begin
      step();
      w++;
    end
    if (exp_data_q.size() != 0) fail_now("drain_timeout");
  endtask

  logic [25:0] v_imm [16];
  logic [3:0]  v_op  [16];
  logic [31:0] v_exp [16];
  logic        v_err [16];

  initial begin
    int base;
    logic [25:0] ri;
    logic [3:0]  ro;
    logic [31:0] rd;
    logic        re;

    v_imm = '{26'h0008001, 26'h0008001, 26'h0008001, 26'h3FFFFFF, 26'h0000080, 26'h0008001,
              26'h0008001, 26'h3FFFFFF, 26'h3FFFF80, 26'h3FF7FFF, 26'h0001234, 26'h2AAAAAA,
              26'h0007FFF, 26'h000007F, 26'h1234567, 26'h0000000};
    v_op  = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd0, 4'd2,
              4'd7, 4'd1, 4'd3, 4'd15, 4'd4, 4'd6, 4'd5, 4'd8};
    v_exp = '{32'hFFFF8001, 32'h80010000, 32'hFFFE0004, 32'h0FFFFFFC, 32'hFFFFFF80, 32'h0,
              32'h00008001, 32'h03FFFFFF, 32'h00000080, 32'h00007FFF, 32'h12340000, 32'h0,
              32'h0001FFFC, 32'h0000007F, 32'h048D159C, 32'h0};
    v_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_imm = '0; b64.in_op = '0; b64.out_ready = 1'b1;
    cur_exp_data = '0; cur_exp_err = 1'b0;
    #2 reset = 1'b0;
    #10;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    #10 reset = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // DW=64 instance: sign extension of LUI beyond bit 31, plain zero extension.
    b64.in_valid = 1'b1; b64.in_imm = 26'h0008001; b64.in_op = 4'd3;
    step();
    check("dw64_lui_valid", 64'(b64.out_valid), 64'd1);
    check("dw64_lui", b64.out_data, 64'hFFFFFFFF80010000);
    b64.in_op = 4'd0;
    step();
    check("dw64_ze16", b64.out_data, 64'h0000000000008001);
    b64.in_valid = 1'b0;
    step();
    check("dw64_cleared", {b64.out_data[62:0], b64.out_valid}, 64'd0);

    // Directed modes, back-to-back, no back-pressure.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(v_imm[i], v_op[i], v_exp[i], v_err[i]);
    wait_drain();

    // Back-pressure: three ops, output stalled four cycles.
    base = n_out;
    bus.out_ready = 1'b0;
    send(26'h0008001, 4'd1, 32'hFFFF8001, 1'b0);
    drive(26'h3FFFFFF, 4'd5, 32'h0FFFFFFC, 1'b0);
`ifdef EXT_PIPE_SKID_EN
    @(negedge clk);
    check("bp_skid_accept", 64'(bus.in_ready), 64'd1);
    step();
    drive(26'h0000080, 4'd6, 32'hFFFFFF80, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      step();
    end
    bus.out_ready = 1'b1;
    wait_accept("bp_release_timeout");
`ifndef EXT_PIPE_SKID_EN
    send(26'h0000080, 4'd6, 32'hFFFFFF80, 1'b0);
`endif
    wait_drain();
    check("bp_out_count", 64'(n_out - base), 64'd3);

    // Flush with a held op and a simultaneous valid input.
    bus.out_ready = 1'b0;
    send(26'h0001234, 4'd3, 32'h12340000, 1'b0);
    drive(26'h0008001, 4'd1, 32'hFFFF8001, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_out_data", 64'(bus.out_data), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    send(26'h0007FFF, 4'd4, 32'h0001FFFC, 1'b0);
    check("post_flush_valid", 64'(bus.out_valid), 64'd1);
    wait_drain();

    // Asynchronous reset while an op is held.
    bus.out_ready = 1'b0;
    send(26'h3FFFFFF, 4'd2, 32'h03FFFFFF, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    check("midrst_out_err", 64'(bus.out_err), 64'd0);
    exp_data_q.delete();
    exp_err_q.delete();
    exp_cyc_q.delete();
    #9 reset = 1'b1;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("midrst_no_pulse", 64'(bus.out_valid), 64'd0);
    send(26'h0000080, 4'd7, 32'h00000080, 1'b0);
    wait_drain();

    // Throughput: 100 random ops, one per cycle, one-cycle latency.
    base = n_out;
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ri = 26'($urandom());
      ro = 4'($urandom_range(0, 15));
      model(ri, ro, rd, re);
      drive(ri, ro, rd, re);
      step();
    end
    bus.in_valid = 1'b0;
    wait_drain();
    lat_chk = 1'b0;
    check("tput_out_count", 64'(n_out - base), 64'd100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
